// File: rtl/cpc_kbd_pkg.sv
// Shared types and constants for the CPC keyboard event path:
// the PS/2 event record, special scancodes and the injector FSM states.
package cpc_kbd_pkg;

  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_ESC    = 8'h76;

  typedef struct packed {
    logic       toggle;
    logic       press;
    logic       ext;
    logic [7:0] code;
  } kbd_evt_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT_DN,
    ST_KEY_DN,
    ST_HOLD,
    ST_KEY_UP,
    ST_SHIFT_UP,
    ST_GAP
  } inj_state_e;

  function automatic logic [9:0] evt_bits(input logic press, input logic ext,
                                          input logic [7:0] code);
    return {press, ext, code};
  endfunction

endpackage

// File: rtl/key_inj_fifo.sv
// Synchronous FIFO for queued auto-type characters; registered read data,
// wrap-bit pointers, flush clears the queue.
module key_inj_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, rd_q;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] dout_q;
  logic         do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = dout_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       dout_q <= '0;
    else if (do_pop) dout_q <= mem_q[rd_q[AW-1:0]];
  end

endmodule

// File: rtl/key_inject_ctrl.sv
// Merges the live PS/2 key stream with a queued auto-type injector that
// sequences each character as scan-tick timed press/release events.
module key_inject_ctrl
  import cpc_kbd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned HOLD_TICKS = 2,
  parameter int unsigned GAP_TICKS  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_tick,
  input  logic [10:0] ps2_key_in,
  input  logic [9:0]  inj_data,
  input  logic        inj_valid,
  output logic        inj_ready,
  output logic [10:0] ps2_key_out,
  output logic        key_extended,
  output logic        busy
);

  localparam int unsigned MAXT = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
  localparam int unsigned CW   = $clog2(MAXT + 1);

  inj_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          ent_q;
  logic [8:0]    cur_q, cur_d;
  logic          key_dn_q, key_dn_d, sh_dn_q, sh_dn_d, abort_q, abort_d;
  logic          tog_q;
  kbd_evt_t      out_q;

  logic          fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_flush;
  logic [9:0]    fifo_dout;
  logic          live_chg, esc_abort, tick_ok, emit;
  logic [9:0]    evt;

  assign live_chg  = ps2_key_in[10] ^ tog_q;
  assign esc_abort = live_chg && (state_q != ST_IDLE) &&
                     (ps2_key_in[9:0] == evt_bits(1'b1, 1'b0, SC_ESC));
  // The first cycle of a wait state never counts a tick.
  assign tick_ok   = scan_tick && !ent_q;

  assign fifo_push    = inj_valid && !fifo_full && !esc_abort;
  assign inj_ready    = !fifo_full;
  assign busy         = (state_q != ST_IDLE) || !fifo_empty;
  assign ps2_key_out  = out_q;
  assign key_extended = out_q.ext;

  key_inj_fifo #(.DEPTH(FIFO_DEPTH), .W(10)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (inj_data),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ent_q    <= 1'b0;
      cur_q    <= '0;
      key_dn_q <= 1'b0;
      sh_dn_q  <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ent_q    <= (state_d != state_q);
      cnt_q    <= (state_d != state_q) ? '0 : cnt_q + CW'(tick_ok);
      cur_q    <= cur_d;
      key_dn_q <= key_dn_d;
      sh_dn_q  <= sh_dn_d;
      abort_q  <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    abort_d = abort_q;
    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (!fifo_empty && !live_chg) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        cur_d   = fifo_dout[8:0];
        state_d = fifo_dout[9] ? ST_SHIFT_DN : ST_KEY_DN;
      end
      ST_SHIFT_DN: if (tick_ok) state_d = ST_KEY_DN;
      ST_KEY_DN:   state_d = ST_HOLD;
      ST_HOLD:     if (tick_ok && cnt_q == CW'(HOLD_TICKS - 1)) state_d = ST_KEY_UP;
      ST_KEY_UP:   state_d = sh_dn_q ? ST_SHIFT_UP : (abort_q ? ST_IDLE : ST_GAP);
      ST_SHIFT_UP: state_d = abort_q ? ST_IDLE : ST_GAP;
      ST_GAP:      if (tick_ok && cnt_q == CW'(GAP_TICKS - 1)) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    // Abort unwinds through the normal release states, skipping whatever is not down.
    if (esc_abort) begin
      abort_d = 1'b1;
      if (key_dn_q)     state_d = ST_KEY_UP;
      else if (sh_dn_q) state_d = ST_SHIFT_UP;
      else begin
        state_d = ST_IDLE;
        abort_d = 1'b0;
      end
    end
  end

  always_comb begin
    emit       = 1'b0;
    evt        = '0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    key_dn_d   = key_dn_q;
    sh_dn_d    = sh_dn_q;
    case (state_q)
      ST_IDLE: begin
        if (live_chg) begin
          emit = 1'b1;
          evt  = ps2_key_in[9:0];
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
        end
      end
      ST_SHIFT_DN: if (ent_q) begin
        emit    = 1'b1;
        evt     = evt_bits(1'b1, 1'b0, SC_LSHIFT);
        sh_dn_d = 1'b1;
      end
      ST_KEY_DN: begin
        emit     = 1'b1;
        evt      = {1'b1, cur_q};
        key_dn_d = 1'b1;
      end
      ST_KEY_UP: begin
        emit     = 1'b1;
        evt      = {1'b0, cur_q};
        key_dn_d = 1'b0;
      end
      ST_SHIFT_UP: begin
        emit    = 1'b1;
        evt     = evt_bits(1'b0, 1'b0, SC_LSHIFT);
        sh_dn_d = 1'b0;
      end
      default: ;
    endcase
    if (esc_abort) begin
      emit       = 1'b0;
      key_dn_d   = key_dn_q;
      sh_dn_d    = sh_dn_q;
      fifo_pop   = 1'b0;
      fifo_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tog_q <= 1'b0;
      out_q <= '0;
    end else begin
      tog_q <= ps2_key_in[10];
      if (emit) out_q <= {~out_q.toggle, evt};
    end
  end

endmodule

// File: tb/tb_key_inject_ctrl.sv
// Directed bench for key_inject_ctrl: expected key events are queued as stimulus
// is applied and matched in order as the merged stream toggles.
module tb_key_inject_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        scan_tick;
  logic [10:0] ps2_key_in;
  logic [9:0]  inj_data;
  logic        inj_valid;
  logic        inj_ready;
  logic [10:0] ps2_key_out;
  logic        key_extended;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  int          n_ev   = 0;
  logic        prev_tog = 1'b0;
  logic [10:0] exp_q[$];
  logic [10:0] expv;

  always #5 clk = ~clk;

  key_inject_ctrl #(.FIFO_DEPTH(16), .HOLD_TICKS(2), .GAP_TICKS(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .scan_tick    (scan_tick),
    .ps2_key_in   (ps2_key_in),
    .inj_data     (inj_data),
    .inj_valid    (inj_valid),
    .inj_ready    (inj_ready),
    .ps2_key_out  (ps2_key_out),
    .key_extended (key_extended),
    .busy         (busy)
  );

  // Scoreboard: every toggle of the output stream must match the next queued event.
  always @(negedge clk) begin
    if (reset) begin
      prev_tog = ps2_key_out[10];
    end else if (ps2_key_out[10] !== prev_tog) begin
      prev_tog = ps2_key_out[10];
      n_ev++;
      if (exp_q.size() != 0) expv = exp_q.pop_front();
      else                   expv = 11'h7FF;
      checks++;
      assert ({1'b0, ps2_key_out[9:0]} === expv) else begin
        errors++;
        $error("FAIL event%0d: observed %h expected %h", n_ev, ps2_key_out[9:0], expv);
      end
      if (expv != 11'h7FF) begin
        checks++;
        assert (key_extended === expv[8]) else begin
          errors++;
          $error("FAIL key_ext%0d: observed %b expected %b", n_ev, key_extended, expv[8]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick();
    scan_tick = 1'b1;
    step(1);
    scan_tick = 1'b0;
    step(4);
  endtask

  task automatic push(input logic [9:0] d);
    inj_valid = 1'b1;
    inj_data  = d;
    step(1);
    inj_valid = 1'b0;
  endtask

  task automatic live(input logic press, input logic ext, input logic [7:0] code);
    ps2_key_in = {~ps2_key_in[10], press, ext, code};
    step(1);
  endtask

  task automatic expect_ev(input logic [9:0] d);
    exp_q.push_back({1'b0, d});
  endtask

  task automatic wait_ev(input int target, input int budget, input string tag);
    int k = 0;
    while (n_ev < target && k < budget) begin
      step(1);
      k++;
    end
    chk(tag, n_ev, target);
  endtask

  initial begin
    int b;
    logic [9:0] d;
    reset      = 1'b1;
    scan_tick  = 1'b0;
    ps2_key_in = '0;
    inj_data   = '0;
    inj_valid  = 1'b0;
    #2;
    chk("rst_out", ps2_key_out, 11'h000);
    chk("rst_ext", key_extended, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", inj_ready, 1'b1);
    step(2);
    reset = 1'b0;
    step(2);

    // Live forwarding while idle
    expect_ev(10'h21C);
    live(1'b1, 1'b0, 8'h1C);
    chk("live_press", ps2_key_out, 11'h61C);
    chk("live_busy", busy, 1'b0);
    expect_ev(10'h01C);
    live(1'b0, 1'b0, 8'h1C);
    chk("live_release", ps2_key_out, 11'h01C);
    step(2);

    // Plain character: hold 2 ticks, gap 1 tick
    b = n_ev;
    expect_ev(10'h215);
    expect_ev(10'h015);
    push(10'h015);
    wait_ev(b + 1, 10, "q_press");
    step(2);
    chk("q_busy_hold", busy, 1'b1);
    tick();
    chk("q_hold_1tick", n_ev, b + 1);
    tick();
    wait_ev(b + 2, 6, "q_release");
    chk("q_busy_gap", busy, 1'b1);
    tick();
    chk("q_busy_done", busy, 1'b0);

    // Shifted character
    b = n_ev;
    expect_ev(10'h212);
    expect_ev(10'h21C);
    expect_ev(10'h01C);
    expect_ev(10'h012);
    push(10'h21C);
    wait_ev(b + 1, 10, "sa_shift_dn");
    step(4);
    chk("sa_wait_tick", n_ev, b + 1);
    tick();
    wait_ev(b + 2, 6, "sa_key_dn");
    step(2);
    tick();
    chk("sa_hold_1tick", n_ev, b + 2);
    tick();
    wait_ev(b + 4, 8, "sa_releases");
    tick();
    chk("sa_busy_done", busy, 1'b0);

    // Fill the queue while the FSM holds a key, then drain with wrap-around
    b = n_ev;
    expect_ev(10'h244);
    expect_ev(10'h044);
    push(10'h044);
    wait_ev(b + 1, 10, "prime_press");
    step(2);
    for (int i = 0; i < 17; i++) begin
      d = {1'b0, 1'(i), 8'(8'h20 + i)};
      if (i < 16) begin
        expect_ev({1'b1, d[8:0]});
        expect_ev({1'b0, d[8:0]});
      end
      push(d);
      if (i == 14) chk("fill_ready15", inj_ready, 1'b1);
      if (i == 15) chk("fill_full16", inj_ready, 1'b0);
    end
    chk("fill_still_full", inj_ready, 1'b0);
    for (int k = 0; k < 150 && busy; k++) tick();
    chk("drain_busy", busy, 1'b0);
    chk("drain_count", n_ev, b + 34);
    chk("drain_sb_empty", exp_q.size(), 0);

    // Esc abort during hold of a shifted key; concurrent push discarded
    b = n_ev;
    expect_ev(10'h212);
    expect_ev(10'h21B);
    push(10'h21B);
    wait_ev(b + 1, 10, "esc_shift_dn");
    step(2);
    tick();
    wait_ev(b + 2, 6, "esc_key_dn");
    step(2);
    push(10'h02A);
    live(1'b1, 1'b0, 8'h1C);
    expect_ev(10'h01B);
    expect_ev(10'h012);
    inj_valid  = 1'b1;
    inj_data   = 10'h02B;
    ps2_key_in = {~ps2_key_in[10], 1'b1, 1'b0, 8'h76};
    step(1);
    inj_valid = 1'b0;
    wait_ev(b + 4, 8, "esc_releases");
    step(2);
    chk("esc_busy", busy, 1'b0);
    tick();
    tick();
    chk("esc_no_more", n_ev, b + 4);
    expect_ev(10'h076);
    live(1'b0, 1'b0, 8'h76);
    step(2);
    chk("esc_idle_fwd", n_ev, b + 5);

    // Asynchronous reset mid-hold
    b = n_ev;
    expect_ev(10'h233);
    push(10'h033);
    wait_ev(b + 1, 10, "rst_hold_press");
    step(2);
    push(10'h034);
    #2;
    reset      = 1'b1;
    ps2_key_in = '0;
    #2;
    chk("arst_out", ps2_key_out, 11'h000);
    chk("arst_ext", key_extended, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_ready", inj_ready, 1'b1);
    step(2);
    reset = 1'b0;
    step(5);
    chk("arst_q_empty", busy, 1'b0);
    chk("arst_no_ev", n_ev, b + 1);
    expect_ev(10'h25A);
    live(1'b1, 1'b0, 8'h5A);
    chk("arst_live", ps2_key_out, 11'h65A);
    step(3);
    chk("final_sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
